// File: rtl/fps_pkg.sv
// Shared field widths, constants and result classification for the fps subtractor.
package fps_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        RK_NORM,
        RK_ZERO,
        RK_INF,
        RK_NAN,
        RK_OVF,
        RK_UNF
    } res_kind_e;

endpackage

// File: rtl/fps_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fps_lzc (
    input  logic [26:0] d_i,
    output logic [4:0]  cnt_o
);

    always_comb begin
        cnt_o = 5'd27;
        for (int unsigned i = 0; i < 27; i++) begin
            if (d_i[i]) cnt_o = 5'(26 - i);
        end
    end

endmodule

// File: rtl/fps.sv
// Single-precision subtractor c = a - b, one registered stage, flush-to-zero, RNE.
// Define FPS_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags port.
module fps
    import fps_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    input  logic        in_valid,
    output logic        out_valid
`ifdef FPS_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    localparam logic signed [9:0] EMAX = 10'(2 * BIAS);

    fp32_t             fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [30:0]       mag_a, mag_b;
    logic              s_l, s_s;
    logic [7:0]        e_l, e_s, e_diff;
    logic [23:0]       sig_l, sig_s;
    logic [4:0]        shamt;
    logic [26:0]       ext_s, aligned, lost_mask;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic              rnd_up;
    logic [24:0]       mant;
    logic [22:0]       frac;
    res_kind_e         kind;
    logic              r_sign;
    logic [31:0]       c_d, c_q;
    logic              out_valid_q;

    assign fa = fp32_t'(a);
    assign fb = fp32_t'({~b[31], b[30:0]});

    always_comb begin
        a_zero = (fa.exp == '0);
        b_zero = (fb.exp == '0);
        a_inf  = (fa.exp == '1) && (fa.man == '0);
        b_inf  = (fb.exp == '1) && (fb.man == '0);
        a_nan  = (fa.exp == '1) && (fa.man != '0);
        b_nan  = (fb.exp == '1) && (fb.man != '0);
        mag_a  = a_zero ? '0 : {fa.exp, fa.man};
        mag_b  = b_zero ? '0 : {fb.exp, fb.man};

        if (mag_a >= mag_b) begin
            s_l   = fa.sign;
            e_l   = fa.exp;
            sig_l = a_zero ? '0 : {1'b1, fa.man};
            s_s   = fb.sign;
            e_s   = fb.exp;
            sig_s = b_zero ? '0 : {1'b1, fb.man};
        end else begin
            s_l   = fb.sign;
            e_l   = fb.exp;
            sig_l = b_zero ? '0 : {1'b1, fb.man};
            s_s   = fa.sign;
            e_s   = fa.exp;
            sig_s = a_zero ? '0 : {1'b1, fa.man};
        end

        // Saturating at 26 parks the hidden bit in the sticky position for huge gaps.
        e_diff    = e_l - e_s;
        shamt     = (e_diff > 8'd26) ? 5'd26 : e_diff[4:0];
        ext_s     = {sig_s, 3'b000};
        lost_mask = ~(27'h7FF_FFFF << shamt);
        aligned   = (ext_s >> shamt) | {26'b0, |(ext_s & lost_mask)};

        if (s_l ^ s_s) sum = {1'b0, sig_l, 3'b000} - {1'b0, aligned};
        else           sum = {1'b0, sig_l, 3'b000} + {1'b0, aligned};
    end

    fps_lzc u_lzc (
        .d_i  (sum[26:0]),
        .cnt_o(lz)
    );

    always_comb begin
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, e_l}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, e_l}) - $signed({5'b00000, lz});
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant   = {1'b0, norm[26:3]} + {24'b0, rnd_up};
        if (mant[24]) begin
            exp_r = exp_n + 10'sd1;
            frac  = mant[23:1];
        end else begin
            exp_r = exp_n;
            frac  = mant[22:0];
        end
    end

    always_comb begin
        kind   = RK_NORM;
        r_sign = s_l;
        if (a_nan || b_nan) begin
            kind = RK_NAN;
        end else if (a_inf && b_inf) begin
            kind   = (fa.sign == fb.sign) ? RK_INF : RK_NAN;
            r_sign = fa.sign;
        end else if (a_inf) begin
            kind   = RK_INF;
            r_sign = fa.sign;
        end else if (b_inf) begin
            kind   = RK_INF;
            r_sign = fb.sign;
        end else if (a_zero && b_zero) begin
            kind   = RK_ZERO;
            r_sign = fa.sign & fb.sign;
        end else if (sum == '0) begin
            kind   = RK_ZERO;
            r_sign = 1'b0;
        end else if (exp_r > EMAX) begin
            kind = RK_OVF;
        end else if (exp_r < 10'sd1) begin
            kind = RK_UNF;
        end
    end

    always_comb begin
        c_d = '0;
        case (kind)
            RK_NAN:         c_d = QNAN;
            RK_INF, RK_OVF: c_d = {r_sign, 8'hFF, 23'b0};
            RK_ZERO:        c_d = {r_sign, 31'b0};
            RK_UNF:         c_d = '0;
            default:        c_d = {r_sign, exp_r[7:0], frac};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) c_q <= c_d;
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;

`ifdef FPS_FLAGS_EN
    logic [3:0] flags_d, flags_q;

    assign flags_d = {kind == RK_NAN,
                      kind == RK_OVF,
                      kind == RK_UNF,
                      (kind == RK_OVF) || (kind == RK_UNF) || ((kind == RK_NORM) && (|norm[2:0]))};

    always_ff @(posedge clk) begin
        if (rst)           flags_q <= '0;
        else if (in_valid) flags_q <= flags_d;
    end

    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fps.sv
// Directed self-checking bench for fps; flag checks are compiled in with FPS_FLAGS_EN.
module tb_fps;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, c;
    logic        in_valid, out_valid;
    int          checks = 0;
    int          errors = 0;
`ifdef FPS_FLAGS_EN
    logic [3:0]  flags;
`endif

    always #5 clk = ~clk;

    fps dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .in_valid (in_valid),
        .out_valid(out_valid)
`ifdef FPS_FLAGS_EN
        ,
        .flags    (flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [3:0] ef);
`ifdef FPS_FLAGS_EN
        check({tag, "_flags"}, {28'b0, flags}, {28'b0, ef});
`else
        if (ef === 4'bxxxx) check({tag, "_flags"}, 32'd0, 32'd1);
`endif
    endtask

    task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ec, input logic [3:0] ef);
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check(tag, c, ec);
        check({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
        check_flags(tag, ef);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h3F98_0000;
        b        = 32'h3F90_0000;
        @(posedge clk);
        #1;
        check("reset_c", c, 32'h0);
        check("reset_ov", {31'b0, out_valid}, 32'd0);
        check_flags("reset", 4'b0000);

        // First valid result must land exactly one edge after rst drops.
        @(negedge clk);
        rst = 1'b0;
        a   = 32'h3F98_0000;
        b   = 32'h3F10_0000;
        @(posedge clk);
        #1;
        check("post_reset_c", c, 32'h3F20_0000);
        check("post_reset_ov", {31'b0, out_valid}, 32'd1);

        run("sub_small",   32'h3F98_0000, 32'h3F90_0000, 32'h3D80_0000, 4'b0000);
        run("sub_align",   32'h3F98_0000, 32'h3F10_0000, 32'h3F20_0000, 4'b0000);
        run("x_minus_x",   32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000);
        run("subnormal",   32'h0040_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000);
        run("overflow",    32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4'b0101);
        run("inf_inf",     32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000);
        // 1 - 2^-24 is exactly representable; the tie case is 1 + 2^-24.
        run("one_m_ulp",   32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, 4'b0000);
        run("tie_even",    32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000, 4'b0001);
        run("nan_in",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
        run("inf_m_fin",   32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b0000);
        run("fin_m_inf",   32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 4'b0000);
        run("inf_m_ninf",  32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 4'b0000);
        run("nzero_pzero", 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0000);
        run("neg_result",  32'h4000_0000, 32'h4040_0000, 32'hBF80_0000, 4'b0000);
        run("round_up_ex", 32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 4'b0001);
        run("huge_diff",   32'h5F80_0000, 32'h3F80_0000, 32'h5F80_0000, 4'b0001);
        run("underflow",   32'h0080_0000, 32'h00C0_0000, 32'h0000_0000, 4'b0011);
        run("last_valid",  32'h3F98_0000, 32'h3F90_0000, 32'h3D80_0000, 4'b0000);

        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'h4000_0000;
        b        = 32'h3F80_0000;
        @(posedge clk);
        #1;
        check("hold_c", c, 32'h3D80_0000);
        check("hold_ov", {31'b0, out_valid}, 32'd0);

        // Reset with an operation in flight discards it.
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h3F98_0000;
        b        = 32'h3F10_0000;
        @(posedge clk);
        #1;
        check("flight_rst_c", c, 32'h0);
        check("flight_rst_ov", {31'b0, out_valid}, 32'd0);
        check_flags("flight_rst", 4'b0000);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume_c", c, 32'h3F20_0000);
        check("resume_ov", {31'b0, out_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
